// File: rtl/picosoc_iomem_initiator.sv
// Single-outstanding command-to-picosoc-iomem bridge: IDLE accepts, REQ drives the bus, RSP holds the result.
// Define IOMEM_INITIATOR_TIMEOUT_EN to abort REQ after TIMEOUT_CYCLES without iomem_ready.
module picosoc_iomem_initiator #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        timeout;

`ifdef IOMEM_INITIATOR_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q, cnt_d;

  // Timeout fires in the REQ cycle whose edge would bring the count up to the limit.
  assign timeout = (cnt_q + 16'd1) == TimeoutLimit;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && cmd_valid) begin
      cnt_d = 16'd0;
    end else if (state_q == REQ && !iomem_ready && !timeout) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unusedTimeoutParam;
  assign unusedTimeoutParam = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_write ? cmd_wstrb : 4'b0000;
          state_d = REQ;
        end
      end
      REQ: begin
        // A ready on the timeout edge still counts as a normal completion.
        if (iomem_ready) begin
          rdata_d = iomem_rdata;
          err_d   = 1'b0;
          state_d = RSP;
        end else if (timeout) begin
          rdata_d = 32'hFFFF_FFFF;
          err_d   = 1'b1;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign iomem_valid = (state_q == REQ);
  assign iomem_addr  = addr_q;
  assign iomem_wdata = wdata_q;
  assign iomem_wstrb = iomem_valid ? wstrb_q : 4'b0000;
  assign rsp_valid   = (state_q == RSP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;

endmodule

// File: tb/tb_picosoc_iomem_initiator.sv
// Randomized self-checking bench for picosoc_iomem_initiator; expectations come from a
// transaction-level model (bus fields, latency = responder delay + 2, in-order read data).
module tb_picosoc_iomem_initiator;

  localparam int TbTimeout = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic [3:0]  cmd_wstrb = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata = 32'd0;

  int errors = 0;
  int checks = 0;
  logic [31:0] rdataQueue[$];

  picosoc_iomem_initiator #(.TIMEOUT_CYCLES(TbTimeout)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction: the responder raises ready once valid has been up for delay cycles.
  task automatic applyStimulus(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input int delay, input logic [31:0] rdata,
                               input int hold);
    logic [3:0]  expStrb;
    logic [31:0] expData;
    expStrb = write ? strb : 4'b0000;
    rdataQueue.push_back(rdata);
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = write; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    step();
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom);
    for (int k = 1; k <= delay + 1; k++) begin
      checkOutput("req_valid", 32'(iomem_valid), 32'd1);
      checkOutput("req_addr", iomem_addr, addr);
      checkOutput("req_wdata", iomem_wdata, wdata);
      checkOutput("req_wstrb", 32'(iomem_wstrb), 32'(expStrb));
      checkOutput("req_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("req_cmd_ready", 32'(cmd_ready), 32'd0);
      if (k == delay + 1) begin
        iomem_ready = 1'b1;
        iomem_rdata = rdata;
      end
      step();
    end
    iomem_ready = 1'b0;
    iomem_rdata = $urandom;
    expData = rdataQueue.pop_front();
    checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rsp_rdata", rsp_rdata, expData);
    checkOutput("rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("rsp_iomem_valid", 32'(iomem_valid), 32'd0);
    checkOutput("rsp_iomem_wstrb", 32'(iomem_wstrb), 32'd0);
    checkOutput("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
    if (hold > 0) rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      iomem_ready = 1'($urandom_range(0, 1));
      step();
      checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_rsp_rdata", rsp_rdata, expData);
      checkOutput("hold_iomem_valid", 32'(iomem_valid), 32'd0);
      checkOutput("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    iomem_ready = 1'b0;
    rsp_ready = 1'b1;
    step();
    checkOutput("done_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("done_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("done_iomem_valid", 32'(iomem_valid), 32'd0);
  endtask

  initial begin
    step();
    step();
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_iomem_valid", 32'(iomem_valid), 32'd0);
    checkOutput("reset_iomem_wstrb", 32'(iomem_wstrb), 32'd0);
    checkOutput("reset_iomem_addr", iomem_addr, 32'd0);
    checkOutput("reset_iomem_wdata", iomem_wdata, 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
    resetn = 1'b1;
    step();

    applyStimulus(1'b0, 32'h0200_0010, 32'h1234_5678, 4'hF, 1, 32'h0000_0001, 0);
    applyStimulus(1'b1, 32'h0300_0000, 32'hA5A5_A5A5, 4'b0101, 1, 32'hDEAD_BEEF, 0);
    applyStimulus(1'b0, 32'h0300_0004, 32'h0, 4'h0, 2, 32'hCAFE_F00D, 10);
    applyStimulus(1'b1, 32'h0300_0008, 32'h5555_AAAA, 4'h0, 0, 32'h0BAD_0BAD, 0);

    for (int t = 0; t < 20; t++) begin
      applyStimulus(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 3),
                    $urandom, $urandom_range(0, 2));
    end

    // Reset while the bus request is outstanding.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0300_0100; cmd_wdata = 32'h1111_2222;
    cmd_wstrb = 4'hF;
    step();
    cmd_valid = 1'b0;
    step();
    checkOutput("rstreq_valid_before", 32'(iomem_valid), 32'd1);
    resetn = 1'b0;
    step();
    checkOutput("rstreq_iomem_valid", 32'(iomem_valid), 32'd0);
    checkOutput("rstreq_iomem_addr", iomem_addr, 32'd0);
    checkOutput("rstreq_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    resetn = 1'b1;
    step();
    checkOutput("rstreq_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rstreq_rsp_valid_after", 32'(rsp_valid), 32'd0);

    // Reset while a response is pending.
    cmd_valid = 1'b1; cmd_write = 1'b0;
    step();
    cmd_valid = 1'b0; iomem_ready = 1'b1; iomem_rdata = 32'h7777_8888;
    step();
    iomem_ready = 1'b0; rsp_ready = 1'b0;
    checkOutput("rstrsp_valid_before", 32'(rsp_valid), 32'd1);
    resetn = 1'b0;
    step();
    checkOutput("rstrsp_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rstrsp_rsp_rdata", rsp_rdata, 32'd0);
    resetn = 1'b1; rsp_ready = 1'b1;
    step();
    checkOutput("rstrsp_cmd_ready", 32'(cmd_ready), 32'd1);

`ifdef IOMEM_INITIATOR_TIMEOUT_EN
    // Responder never answers: valid lasts exactly TbTimeout cycles, then an error response.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0300_0200;
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < TbTimeout; k++) begin
      checkOutput("to_iomem_valid", 32'(iomem_valid), 32'd1);
      step();
    end
    checkOutput("to_iomem_valid_drop", 32'(iomem_valid), 32'd0);
    checkOutput("to_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("to_rsp_err", 32'(rsp_err), 32'd1);
    checkOutput("to_rsp_rdata", rsp_rdata, 32'hFFFF_FFFF);
    rsp_ready = 1'b0;
    iomem_ready = 1'b1; iomem_rdata = 32'h1234_0000;
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("to_late_rsp_rdata", rsp_rdata, 32'hFFFF_FFFF);
      checkOutput("to_late_rsp_err", 32'(rsp_err), 32'd1);
      checkOutput("to_late_iomem_valid", 32'(iomem_valid), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    checkOutput("to_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    checkOutput("to_spurious_rsp_valid", 32'(rsp_valid), 32'd0);
    iomem_ready = 1'b0;
    applyStimulus(1'b0, 32'h0300_0300, 32'h0, 4'h0, TbTimeout - 1, 32'h4242_4242, 0);
`else
    applyStimulus(1'b1, 32'h0300_0400, 32'h9999_0000, 4'b1000, 40, 32'h600D_600D, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
